fp_normalize_stage: RTL and testbench

Final normalization stage of the floating point addition pipeline. It takes the unnormalized two's-complement sum produced after significand alignment and addition. It converts the sum to sign/magnitude, counts leading zeros, left-shifts to restore the hidden bit, adjusts the exponent, handles special results, and packs an IEEE-754 word. It is a two-stage registered pipeline with valid tracking and a global stall.

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_leading_zero_count.sv | 14 +
 rtl/fp_normalize_stage.sv | 84 ++++++++
 tb/tb_fp_normalize_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point constants and the normalize stage-A register bundle.
package fp_pkg;
   localparam int FP_EXPONENT_WIDTH = 8;
   localparam int FP_SIGNIFICAND_WIDTH = 23;
   localparam int FP_LZ_WIDTH = $clog2(FP_SIGNIFICAND_WIDTH + 2);
   localparam logic [FP_EXPONENT_WIDTH-1:0] FP_EXP_ALL_ONES = '1;
   localparam logic [FP_SIGNIFICAND_WIDTH-1:0] FP_QNAN_FRACTION = {1'b1, {(FP_SIGNIFICAND_WIDTH-1){1'b0}}};
   typedef struct packed {
      logic sign;
      logic [FP_SIGNIFICAND_WIDTH+1:0] magnitude;
      logic [FP_LZ_WIDTH-1:0] lz;
      logic [FP_EXPONENT_WIDTH-1:0] exponent;
      logic is_inf;
      logic is_nan;
      logic inf_sign;
      logic valid;
   } fp_stage_a_t;
endpackage

// File: rtl/fp_leading_zero_count.sv
// fp_leading_zero_count: combinational priority encoder counting leading zeros from the MSB.
module fp_leading_zero_count #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0]         value,
   output logic [$clog2(WIDTH+1)-1:0] count
);
   localparam int CW = $clog2(WIDTH + 1);
   always_comb begin
      count = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++)
         if (value[i]) count = CW'(WIDTH - 1 - i);
   end
endmodule

// File: rtl/fp_normalize_stage.sv
// fp_normalize_stage: two-stage pipeline turning an aligned two's-complement sum into a packed IEEE-754 word.
module fp_normalize_stage
   import fp_pkg::*;
#(
   parameter int EXPONENT_WIDTH = FP_EXPONENT_WIDTH,
   parameter int SIGNIFICAND_WIDTH = FP_SIGNIFICAND_WIDTH,
   parameter int TOTAL_WIDTH = 1 + EXPONENT_WIDTH + SIGNIFICAND_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall_i,
   input  logic                         valid_i,
   input  logic [SIGNIFICAND_WIDTH+2:0] significand_i,
   input  logic [EXPONENT_WIDTH-1:0]    exponent_i,
   input  logic                         result_is_inf_i,
   input  logic                         result_is_nan_i,
   input  logic                         inf_sign_i,
   output logic                         valid_o,
   output logic [TOTAL_WIDTH-1:0]       result_o
);
   localparam int EW = EXPONENT_WIDTH;
   localparam int SW = SIGNIFICAND_WIDTH;
   localparam int LW = $clog2(SW + 2);
   localparam logic [EW-1:0] EXP_ONES = '1;
   localparam logic [SW-1:0] QNAN_FRAC = {1'b1, {(SW-1){1'b0}}};
   typedef struct packed {
      logic sign;
      logic [SW+1:0] magnitude;
      logic [LW-1:0] lz;
      logic [EW-1:0] exponent;
      logic is_inf;
      logic is_nan;
      logic inf_sign;
      logic valid;
   } stage_a_t;
   stage_a_t a, a_d;
   logic [SW+1:0] magnitude;
   logic [LW-1:0] lz;
   logic [EW:0] exp_ext, exp_inc, lz_ext;
   logic [EW-1:0] exp_dec;
   logic [SW-1:0] shifted;
   logic [TOTAL_WIDTH-1:0] result_d;
   assign magnitude = (SW+2)'(significand_i[SW+2] ? -significand_i : significand_i);
   fp_leading_zero_count #(.WIDTH(SW + 1)) u_lzc (
      .value(magnitude[SW:0]),
      .count(lz)
   );
   always_comb begin
      a_d.sign = significand_i[SW+2];
      a_d.magnitude = magnitude;
      a_d.lz = lz;
      a_d.exponent = exponent_i;
      a_d.is_inf = result_is_inf_i;
      a_d.is_nan = result_is_nan_i;
      a_d.inf_sign = inf_sign_i;
      a_d.valid = valid_i;
   end
   always_ff @(posedge clk)
      if (reset) a <= '0;
      else if (!stall_i) a <= a_d;
   // Exponents widened by one bit so exp+1 and the exp <= lz flush test never wrap.
   always_comb begin
      exp_ext = {1'b0, a.exponent};
      exp_inc = exp_ext + 1'b1;
      lz_ext = (EW+1)'(a.lz);
      exp_dec = a.exponent - EW'(a.lz);
      shifted = SW'(a.magnitude[SW:0] << a.lz);
      result_d = a.is_nan ? {1'b0, EXP_ONES, QNAN_FRAC}
               : a.is_inf ? {a.inf_sign, EXP_ONES, {SW{1'b0}}}
               : a.magnitude == '0 ? '0
               : a.magnitude[SW+1] ? (exp_inc == {1'b0, EXP_ONES} ? {a.sign, EXP_ONES, {SW{1'b0}}}
                                                                  : {a.sign, exp_inc[EW-1:0], a.magnitude[SW:1]})
               : exp_ext <= lz_ext ? {a.sign, {(EW+SW){1'b0}}}
               : {a.sign, exp_dec, shifted};
   end
   always_ff @(posedge clk)
      if (reset) begin
         valid_o <= 1'b0;
         result_o <= '0;
      end else if (!stall_i) begin
         valid_o <= a.valid;
         result_o <= result_d;
      end
endmodule

// File: tb/tb_fp_normalize_stage.sv
// tb_fp_normalize_stage: directed and random checks of fp_normalize_stage against a real-number reference model.
module tb_fp_normalize_stage;
   logic clk = 0;
   logic reset = 1;
   logic stall_i = 0;
   logic valid_i = 0;
   logic [25:0] significand_i = '0;
   logic [7:0] exponent_i = '0;
   logic result_is_inf_i = 0;
   logic result_is_nan_i = 0;
   logic inf_sign_i = 0;
   logic valid_o;
   logic [31:0] result_o;

   fp_normalize_stage dut (
      .clk(clk),
      .reset(reset),
      .stall_i(stall_i),
      .valid_i(valid_i),
      .significand_i(significand_i),
      .exponent_i(exponent_i),
      .result_is_inf_i(result_is_inf_i),
      .result_is_nan_i(result_is_nan_i),
      .inf_sign_i(inf_sign_i),
      .valid_o(valid_o),
      .result_o(result_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int adv;
   } exp_t;
   exp_t q[$];
   int total = 0;
   int bad = 0;
   int adv = 0;
   logic chk_rst = 1;
   logic prev_stall = 0;
   logic last_v = 0;
   logic [31:0] last_r = '0;

   // Normalizes by repeated doubling of the magnitude instead of counting zeros.
   function automatic logic [31:0] model(logic [25:0] sig, logic [7:0] e, logic inf, logic nan, logic isgn);
      int v, mag, lz;
      logic s;
      if (nan) return 32'h7FC00000;
      if (inf) return {isgn, 8'hFF, 23'd0};
      v = $signed(sig);
      s = v < 0;
      mag = (s ? -v : v) % (1 << 25);
      if (mag == 0) return 32'd0;
      if (mag >= (1 << 24)) begin
         if (int'(e) + 1 == 255) return {s, 8'hFF, 23'd0};
         return {s, 8'(int'(e) + 1), 23'(mag / 2)};
      end
      lz = 0;
      while (mag < (1 << 23)) begin
         mag = mag * 2;
         lz++;
      end
      if (int'(e) <= lz) return {s, 31'd0};
      return {s, 8'(int'(e) - lz), 23'(mag)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, expv);
      end
   endtask

   task automatic sample();
      exp_t it;
      if (chk_rst) begin
         chk("rst_valid", 32'(valid_o), 32'd0);
         chk("rst_result", result_o, 32'd0);
      end else if (prev_stall) begin
         chk("stall_valid", 32'(valid_o), 32'(last_v));
         chk("stall_result", result_o, last_r);
      end else if (valid_o) begin
         if (q.size() == 0) chk("spurious_valid", 32'(valid_o), 32'd0);
         else begin
            it = q.pop_front();
            chk("result", result_o, it.res);
            chk("latency", adv, it.adv + 1);
         end
      end else if (q.size() > 0 && q[0].adv + 1 == adv) begin
         chk("missing_valid", 32'(valid_o), 32'd1);
         void'(q.pop_front());
      end
      last_v = valid_o;
      last_r = result_o;
   endtask

   task automatic cyc(input logic rst_v, input logic v, input logic [25:0] sig, input logic [7:0] e,
                      input logic inf, input logic nan, input logic isgn, input logic st);
      exp_t it;
      @(negedge clk);
      sample();
      reset = rst_v;
      stall_i = st;
      valid_i = v;
      significand_i = sig;
      exponent_i = e;
      result_is_inf_i = inf;
      result_is_nan_i = nan;
      inf_sign_i = isgn;
      chk_rst = rst_v;
      prev_stall = st && !rst_v;
      if (rst_v) q.delete();
      else if (!st) begin
         adv++;
         if (v) begin
            it.res = model(sig, e, inf, nan, isgn);
            it.adv = adv;
            q.push_back(it);
         end
      end
   endtask

   task automatic dv(input logic [25:0] sig, input logic [7:0] e);
      cyc(0, 1, sig, e, 0, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 26'd0, 8'd0, 0, 0, 0, 0);
   endtask

   function automatic logic [25:0] rnd_sig();
      logic [25:0] m;
      m = 26'($urandom & 32'h1FFFFFF) >> $urandom_range(0, 25);
      return $urandom_range(0, 1) ? -m : m;
   endfunction

   initial begin
      cyc(1, 0, 26'd0, 8'd0, 0, 0, 0, 0);
      cyc(1, 0, 26'd0, 8'd0, 0, 0, 0, 0);
      dv(26'h0800000, 8'h7F);
      idle(2);
      dv(26'h1000000, 8'h7F);
      dv(26'h1000000, 8'hFE);
      dv(26'h3800000, 8'h80);
      dv(26'h0000001, 8'h7F);
      dv(26'h0000001, 8'h10);
      dv(26'h0000000, 8'h7F);
      cyc(0, 1, 26'h0800000, 8'h7F, 0, 1, 0, 0);
      cyc(0, 1, 26'h0800000, 8'h7F, 1, 0, 1, 0);
      cyc(0, 1, 26'h0800000, 8'h7F, 1, 1, 1, 0);
      for (int i = 0; i < 5; i++) dv(rnd_sig(), 8'($urandom_range(1, 254)));
      for (int i = 0; i < 3; i++) cyc(0, 1, rnd_sig(), 8'h55, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) dv(rnd_sig(), 8'($urandom_range(1, 254)));
      idle(3);
      dv(26'h0C00000, 8'h40);
      dv(26'h3F00000, 8'h90);
      cyc(1, 1, 26'h0800000, 8'h7F, 0, 0, 0, 1);
      idle(3);
      for (int i = 0; i < 400; i++) begin
         logic nan, inf;
         nan = $urandom_range(0, 15) == 0;
         inf = $urandom_range(0, 15) == 0;
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, rnd_sig(),
             8'($urandom_range(0, 254)), inf, nan, 1'($urandom), $urandom_range(0, 9) == 0);
      end
      idle(4);
      @(negedge clk);
      sample();
      chk("queue_empty", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
